// File: rtl/cmd_encoder.sv
// cmd_encoder: five raw player buttons -> queued 16-bit movement commands
// (1 right, 2 left, 3 up, 4 down, 5 exit) on a valid/ready port.
// Each button is synchronised, debounced and edge-detected. One press is
// pushed per cycle into a small FIFO whose head is presented downstream.
// Optional feature macro: VERPG_HOLD_REPEAT_EN (auto-repeat of a held direction).
//
// Handshake: o_cmd_valid is high while the FIFO holds a command and the exit
// has not yet been handed off; o_cmd_data is held stable while
// o_cmd_valid && !i_cmd_ready; a command is consumed on any edge where
// o_cmd_valid && i_cmd_ready.
module cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 16,
    parameter int CMD_W           = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [4:0]                    i_btn,
    output logic [CMD_W-1:0]              o_cmd_data,
    output logic                          o_cmd_valid,
    input  logic                          i_cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_done
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [2:0]       CODE_EXIT = 3'd5;

    // Reject configurations the logic below cannot represent.
    if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("cmd_encoder: illegal parameter value");
    end

    logic [4:0]      r_sync1, r_sync2, r_deb, r_deb_d;
    logic [DB_W-1:0] r_db_cnt [5];
    logic [2:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic            r_overflow, r_done, r_exit_seen;

    logic [4:0] w_press, w_rep, w_evt;
    logic       w_push, w_pop, w_valid, w_full, w_accept;
    logic [2:0] w_code, w_head;

    // Synchronise each button, then accept a level change only after it has
    // differed from the debounced state for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_deb[i]    <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_deb & ~r_deb_d;

`ifdef VERPG_HOLD_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES);

    logic [3:0]      w_held_sel;
    logic [3:0]      r_rep_sel;
    logic [RP_W-1:0] r_rep_cnt;

    // Highest-priority direction currently held (right > left > up > down).
    always_comb begin
        w_held_sel = 4'b0000;
        if (r_deb[0])      w_held_sel = 4'b0001;
        else if (r_deb[1]) w_held_sel = 4'b0010;
        else if (r_deb[2]) w_held_sel = 4'b0100;
        else if (r_deb[3]) w_held_sel = 4'b1000;
    end

    assign w_rep = (r_rep_cnt == RP_LAST && r_rep_sel == w_held_sel && w_held_sel != 4'b0000)
                   ? {1'b0, w_held_sel} : 5'b00000;

    // Cycles since the held direction's last press or repeat; restarts on any change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep_sel <= '0;
            r_rep_cnt <= '0;
        end else if (w_held_sel == 4'b0000) begin
            r_rep_sel <= '0;
            r_rep_cnt <= '0;
        end else if (w_held_sel != r_rep_sel || (w_press[3:0] & w_held_sel) != 4'b0000
                     || w_rep != 5'b00000) begin
            r_rep_sel <= w_held_sel;
            r_rep_cnt <= RP_W'(1);
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep = 5'b00000;
`endif

    assign w_evt = w_press | w_rep;

    // Pick at most one event per cycle: exit > right > left > up > down.
    always_comb begin
        w_push = 1'b0;
        w_code = 3'd0;
        if (!r_exit_seen) begin
            if (w_evt[4]) begin
                w_push = 1'b1; w_code = 3'd5;
            end else if (w_evt[0]) begin
                w_push = 1'b1; w_code = 3'd1;
            end else if (w_evt[1]) begin
                w_push = 1'b1; w_code = 3'd2;
            end else if (w_evt[2]) begin
                w_push = 1'b1; w_code = 3'd3;
            end else if (w_evt[3]) begin
                w_push = 1'b1; w_code = 3'd4;
            end
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign w_valid  = (r_count != '0) && !r_done;
    assign w_pop    = w_valid && i_cmd_ready;
    assign w_full   = (r_count == CNT_FULL);
    assign w_accept = w_push && (!w_full || w_pop);

    // Command FIFO: push/pop, exit overwrite of the tail when full, sticky flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_exit_seen <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_head == CODE_EXIT) r_done <= 1'b1;
            end
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
                if (w_code == CODE_EXIT) r_exit_seen <= 1'b1;
            end else if (w_push) begin
                // Full with no pop: directions are dropped, exit replaces the newest entry.
                r_overflow <= 1'b1;
                if (w_code == CODE_EXIT) begin
                    r_mem[r_wr_ptr - PTR_ONE] <= w_code;
                    r_exit_seen               <= 1'b1;
                end
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    assign o_cmd_valid  = w_valid;
    assign o_cmd_data   = w_valid ? {{(CMD_W-3){1'b0}}, w_head} : '0;
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
    assign o_done       = r_done;

endmodule

// File: tb/tb_cmd_encoder.sv
// Bench for cmd_encoder (default build): directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against a
// queue-based behavioural model.
module tb_cmd_encoder;
  localparam int DB    = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = '0;
  logic        cmd_ready = 1'b0;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        done;

  always #5 clk = ~clk;

  cmd_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH(DEPTH),
    .REPEAT_CYCLES(16),
    .CMD_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn(btn),
    .o_cmd_data(cmd_data),
    .o_cmd_valid(cmd_valid),
    .i_cmd_ready(cmd_ready),
    .o_fifo_count(fifo_count),
    .o_overflow(overflow),
    .o_done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Buttons: two-stage sample delay, then a level is adopted once the
  // delayed sample has disagreed with it for DB cycles in a row.
  // Commands: a plain queue of codes.
  int m_s1 [5];
  int m_s2 [5];
  int m_deb [5];
  int m_prev [5];
  int m_run [5];
  int m_q [$];
  bit m_ovf, m_done, m_exit;

  always @(posedge clk) begin
    int  code;
    bit  vld, pop, full;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_run[i] = 0;
      end
      m_q.delete();
      m_ovf = 0; m_done = 0; m_exit = 0;
    end else begin
      vld  = (m_q.size() > 0) && !m_done;
      pop  = vld && cmd_ready;
      full = (m_q.size() == DEPTH);
      code = 0;
      if (!m_exit) begin
        if (m_deb[4] == 1 && m_prev[4] == 0) code = 5;
        else
          for (int i = 0; i < 4; i++)
            if (code == 0 && m_deb[i] == 1 && m_prev[i] == 0) code = i + 1;
      end
      if (pop) begin
        if (m_q[0] == 5) m_done = 1;
        void'(m_q.pop_front());
      end
      if (code != 0) begin
        if (full && !pop) begin
          m_ovf = 1;
          if (code == 5) begin
            m_q[m_q.size() - 1] = 5;
            m_exit = 1;
          end
        end else begin
          m_q.push_back(code);
          if (code == 5) m_exit = 1;
        end
      end
      for (int i = 0; i < 5; i++) begin
        m_prev[i] = m_deb[i];
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_deb[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(btn[i]);
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    bit exp_valid;
    if (chk_en) begin
      exp_valid = (m_q.size() > 0) && !m_done;
      check("count", int'(fifo_count), m_q.size());
      check("valid", int'(cmd_valid), int'(exp_valid));
      if (exp_valid) check("data", int'(cmd_data), m_q[0]);
      check("overflow", int'(overflow), int'(m_ovf));
      check("done", int'(done), int'(m_done));
    end
  end

  // ---------------- driver tasks ----------------
  int got [$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = '0;
    cmd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic collect(int n);
    repeat (n) begin
      if (cmd_valid && cmd_ready) got.push_back(int'(cmd_data));
      step();
    end
  endtask

  task automatic press(int idx);
    btn[idx] = 1'b1;
    repeat (8) step();
    btn[idx] = 1'b0;
    repeat (8) step();
  endtask

  function automatic int got_at(int k);
    return (got.size() > k) ? got[k] : -1;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!cmd_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int exp_a [4];
    int hold [5];

    do_reset();
    check("reset_count", int'(fifo_count), 0);
    check("reset_valid", int'(cmd_valid), 0);
    check("reset_data", int'(cmd_data), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_done", int'(done), 0);

    // single held press: latency 3+DB, exactly one command
    cmd_ready = 1'b1;
    got.delete();
    btn[0] = 1'b1;
    wait_valid(lat);
    check("t1_latency", lat, 7);
    check("t1_data", int'(cmd_data), 1);
    collect(20);
    btn[0] = 1'b0;
    collect(12);
    check("t1_num_cmds", got.size(), 1);

    // bouncing press then hold -> one command; short glitch -> none
    do_reset();
    cmd_ready = 1'b1;
    got.delete();
    btn[2] = 1'b1; step(); step();
    btn[2] = 1'b0; step(); step();
    btn[2] = 1'b1; step(); step();
    collect(20);
    btn[2] = 1'b0;
    collect(12);
    check("t2_num_cmds", got.size(), 1);
    check("t2_code", got_at(0), 3);
    got.delete();
    btn[2] = 1'b1; step(); step(); step();
    btn[2] = 1'b0;
    collect(20);
    check("t2_glitch_cmds", got.size(), 0);

    // overflow: five directions into a four-entry queue
    do_reset();
    press(0); press(1); press(2); press(3); press(0);
    check("t3_count", int'(fifo_count), 4);
    check("t3_overflow", int'(overflow), 1);
    got.delete();
    cmd_ready = 1'b1;
    collect(10);
    exp_a = '{1, 2, 3, 4};
    check("t3_num_cmds", got.size(), 4);
    for (int k = 0; k < 4; k++) check("t3_drain", got_at(k), exp_a[k]);

    // exit and left rise together -> only exit; done afterwards
    do_reset();
    cmd_ready = 1'b1;
    got.delete();
    btn = 5'b10010;
    collect(20);
    btn = '0;
    collect(10);
    check("t4_num_cmds", got.size(), 1);
    check("t4_code", got_at(0), 5);
    check("t4_done", int'(done), 1);
    got.delete();
    press(1);
    check("t4_after_done_cmds", got.size(), 0);
    check("t4_after_done_valid", int'(cmd_valid), 0);

    // full queue + exit overwrites newest entry
    do_reset();
    press(0); press(1); press(2); press(3); press(4);
    check("t5_count", int'(fifo_count), 4);
    check("t5_overflow", int'(overflow), 1);
    got.delete();
    cmd_ready = 1'b1;
    collect(10);
    exp_a = '{1, 2, 3, 5};
    check("t5_num_cmds", got.size(), 4);
    for (int k = 0; k < 4; k++) check("t5_drain", got_at(k), exp_a[k]);
    check("t5_done", int'(done), 1);

    // reset mid-operation with a held button
    do_reset();
    press(0); press(1);
    check("t6_count_before", int'(fifo_count), 2);
    btn[3] = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("t6_count_after_rst", int'(fifo_count), 0);
    check("t6_valid_after_rst", int'(cmd_valid), 0);
    rst = 1'b0;
    wait_valid(lat);
    check("t6_latency", lat, 7);
    check("t6_code", int'(cmd_data), 4);
    btn = '0;
    cmd_ready = 1'b1;
    collect(12);

    // randomized buttons, backpressure and occasional reset
    do_reset();
    for (int i = 0; i < 5; i++) hold[i] = int'($urandom_range(1, 20));
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < 5; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn[i] = ~btn[i];
          if (i == 4 && btn[i] == 1'b0) hold[i] = int'($urandom_range(150, 600));
          else if ($urandom_range(0, 2) == 0) hold[i] = int'($urandom_range(1, 5));
          else hold[i] = int'($urandom_range(6, 30));
        end
      end
      if (cyc % 8 == 0) cmd_ready = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    btn = '0;
    cmd_ready = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
